res_ram_arbiter: RTL and testbench

//  Shares the single-port res_RAM (8b x 16384; reads at negedge, writes at posedge) among NREQ DT requesters.

---
 rtl/dt_pkg.sv | 18 +
 rtl/res_rr_pick.sv | 37 +++
 rtl/res_ram_arbiter.sv | 152 +++++++++++++++
 tb/tb_res_ram_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dt_pkg.sv
// Shared DT types and constants: image geometry, res_RAM widths and requester ids.
package dt_pkg;

   localparam int IMG_W    = 128;
   localparam int RES_AW   = 14;
   localparam int RES_DW   = 8;
   localparam int DT_NREQ  = 3;
   localparam int REQ_ID_W = $clog2(DT_NREQ);

   typedef logic [RES_AW-1:0]   res_addr_t;
   typedef logic [RES_DW-1:0]   res_data_t;
   typedef logic [REQ_ID_W-1:0] req_id_t;

   localparam req_id_t REQ_LOAD = 2'd0;
   localparam req_id_t REQ_FWD  = 2'd1;
   localparam req_id_t REQ_BWD  = 2'd2;

endpackage

// File: rtl/res_rr_pick.sv
// Rotate-priority one-hot picker: first set request at or above ptr, wrapping to 0.
module res_rr_pick
   import dt_pkg::*;
#(
   parameter int NREQ = DT_NREQ,
   parameter int PW   = $clog2(DT_NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] gnt
);

   int   idx_s;
   logic found_s;

   // Walk the requesters in priority order starting at ptr
   always_comb begin
      gnt     = '0;
      found_s = 1'b0;
      idx_s   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx_s = int'(ptr) + k;
         if (idx_s >= NREQ) begin
            idx_s = idx_s - NREQ;
         end else begin
            idx_s = idx_s;
         end
         if (!found_s && req[idx_s]) begin
            gnt[idx_s] = 1'b1;
            found_s    = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/res_ram_arbiter.sv
// Round-robin arbiter sharing the single-port res_RAM among the DT requesters.
// Optional RES_ARB_LOCK_EN adds a lock port giving a requester exclusive ownership.
module res_ram_arbiter
   import dt_pkg::*;
#(
   parameter int NREQ = DT_NREQ,
   parameter int AW   = RES_AW,
   parameter int DW   = RES_DW
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    we,
   input  logic [NREQ*AW-1:0] addr,
   input  logic [NREQ*DW-1:0] wdata,
`ifdef RES_ARB_LOCK_EN
   input  logic [NREQ-1:0]    lock,
`endif
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    rvalid,
   output logic [DW-1:0]      rdata,
   output logic               busy,
   output logic               res_rd,
   output logic               res_wr,
   output logic [AW-1:0]      res_addr,
   output logic [DW-1:0]      res_do,
   input  logic [DW-1:0]      res_di
);

   localparam int PW = $clog2(NREQ);

   logic [PW-1:0]   ptr_r, id_s, ptr_nxt_s, rd_id_r;
   logic [NREQ-1:0] req_m_s, pick_s, gnt_s, rd_oh_s, rvalid_r;
   logic            xfer_s, we_sel_s, rd_v_r, res_rd_r, res_wr_r, busy_r;
   logic [AW-1:0]   addr_sel_s, res_addr_r;
   logic [DW-1:0]   wdata_sel_s, res_do_r, rdata_r;

`ifdef RES_ARB_LOCK_EN
   logic            own_v_r;
   logic [PW-1:0]   own_id_r;
   logic            lock_sel_s;

   // While owned, only the owner's request reaches the picker
   always_comb begin
      req_m_s = '0;
      if (own_v_r) begin
         req_m_s[own_id_r] = req[own_id_r];
      end else begin
         req_m_s = req;
      end
   end

   assign lock_sel_s = lock[id_s];
`else
   assign req_m_s = req;
`endif

   res_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
      .req (req_m_s),
      .ptr (ptr_r),
      .gnt (pick_s)
   );

   // Grant is forced low while reset is held so nothing can look granted
   assign gnt_s  = pick_s & {NREQ{reset}};
   assign xfer_s = |gnt_s;

   // Decode the winner and select its command fields
   always_comb begin
      id_s = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_s[i]) begin
            id_s = PW'(i);
         end else begin
            id_s = id_s;
         end
      end
      we_sel_s    = we[id_s];
      addr_sel_s  = addr[int'(id_s)*AW +: AW];
      wdata_sel_s = wdata[int'(id_s)*DW +: DW];
      if (int'(id_s) == NREQ-1) begin
         ptr_nxt_s = '0;
      end else begin
         ptr_nxt_s = id_s + PW'(1);
      end
      rd_oh_s          = '0;
      rd_oh_s[rd_id_r] = 1'b1;
   end

   // RAM command bus, read-id pipeline and read-data capture
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         res_rd_r   <= 1'b0;
         res_wr_r   <= 1'b0;
         res_addr_r <= '0;
         res_do_r   <= '0;
         rd_v_r     <= 1'b0;
         rd_id_r    <= '0;
         rvalid_r   <= '0;
         rdata_r    <= '0;
         busy_r     <= 1'b0;
      end else begin
         res_rd_r <= xfer_s & ~we_sel_s;
         res_wr_r <= xfer_s & we_sel_s;
         if (xfer_s) begin
            res_addr_r <= addr_sel_s;
            res_do_r   <= wdata_sel_s;
         end
         rd_v_r   <= xfer_s & ~we_sel_s;
         rd_id_r  <= id_s;
         rvalid_r <= rd_v_r ? rd_oh_s : '0;
         if (rd_v_r) begin
            rdata_r <= res_di;
         end
         // next-cycle view of res_rd|res_wr|rvalid
         busy_r <= xfer_s | rd_v_r;
      end
   end

   // Round-robin pointer and lock ownership
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_r <= '0;
`ifdef RES_ARB_LOCK_EN
         own_v_r  <= 1'b0;
         own_id_r <= '0;
`endif
      end else if (xfer_s) begin
`ifdef RES_ARB_LOCK_EN
         if (lock_sel_s) begin
            own_v_r  <= 1'b1;
            own_id_r <= id_s;
         end else begin
            own_v_r <= 1'b0;
            ptr_r   <= ptr_nxt_s;
         end
`else
         ptr_r <= ptr_nxt_s;
`endif
      end
   end

   assign gnt      = gnt_s;
   assign rvalid   = rvalid_r;
   assign rdata    = rdata_r;
   assign busy     = busy_r;
   assign res_rd   = res_rd_r;
   assign res_wr   = res_wr_r;
   assign res_addr = res_addr_r;
   assign res_do   = res_do_r;

endmodule

// File: tb/tb_res_ram_arbiter.sv
// Randomized self-checking bench for res_ram_arbiter against a transaction-level model.
module tb_res_ram_arbiter;
   import dt_pkg::*;

   localparam int N  = DT_NREQ;
   localparam int AW = RES_AW;
   localparam int DW = RES_DW;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    req, we, gnt, rvalid;
   logic [N*AW-1:0] addr;
   logic [N*DW-1:0] wdata;
   logic [DW-1:0]   rdata, res_do, res_di;
   logic            busy, res_rd, res_wr;
   logic [AW-1:0]   res_addr;
`ifdef RES_ARB_LOCK_EN
   logic [N-1:0]    lock;
`endif

   always #5 clk = ~clk;

   res_ram_arbiter dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
`ifdef RES_ARB_LOCK_EN
      .lock(lock),
`endif
      .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy), .res_rd(res_rd),
      .res_wr(res_wr), .res_addr(res_addr), .res_do(res_do), .res_di(res_di)
   );

   // res_RAM: reads at negedge, writes at posedge
   logic [7:0] ram [0:16383];
   always @(negedge clk) if (res_rd) res_di <= ram[res_addr];
   always @(posedge clk) if (res_wr) ram[res_addr] <= res_do;

   // requester-side pending commands
   logic          p_v [N];
   logic          p_we[N];
   logic [AW-1:0] p_a [N];
   logic [DW-1:0] p_d [N];
   logic          p_lk[N];

   // reference model state
   logic [7:0]    mdl_mem [0:16383];
   int            m_ptr, m_own, cyc, n_err, n_chk;
   logic          m_own_v, e_rd, e_wr;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_do;
   typedef struct { int due; int id; logic [7:0] d; } rd_t;
   rd_t rq[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req[i] = p_v[i];
         we[i]  = p_we[i];
         addr[i*AW +: AW]  = p_a[i];
         wdata[i*DW +: DW] = p_d[i];
`ifdef RES_ARB_LOCK_EN
         lock[i] = p_lk[i];
`endif
      end
   endtask

   task automatic set_req(input int i, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic lk);
      p_v[i] = 1'b1; p_we[i] = w; p_a[i] = a; p_d[i] = d; p_lk[i] = lk;
      drive();
   endtask

   task automatic model_reset();
      m_ptr = 0; m_own = 0; m_own_v = 1'b0;
      e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_do = '0;
      rq.delete();
      for (int i = 0; i < N; i++) p_v[i] = 1'b0;
      drive();
   endtask

   function automatic logic [AW-1:0] pick_addr();
      logic [AW-1:0] a;
      case ($urandom_range(0, 3))
         0:       a = 14'h0081;
         1:       a = 14'h3FFF;
         2:       a = 14'($urandom_range(0, 7));
         default: a = 14'($urandom);
      endcase
      return a;
   endfunction

   // One clock: compare at negedge, advance the model, then retire the granted request
   task automatic cycle();
      logic [N-1:0] eff, eg, ev;
      logic [7:0]   ed;
      int           g;
      @(negedge clk);
      eff = req;
      if (m_own_v) begin
         eff = '0;
         eff[m_own] = req[m_own];
      end
      g  = rr_pick(eff, m_ptr);
      eg = '0;
      if (g >= 0) eg[g] = 1'b1;
      ev = '0; ed = '0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
         ev[rq[0].id] = 1'b1;
         ed = rq[0].d;
         void'(rq.pop_front());
      end
      check("gnt", 32'(gnt), 32'(eg));
      check("res_rd", 32'(res_rd), 32'(e_rd));
      check("res_wr", 32'(res_wr), 32'(e_wr));
      check("res_addr", 32'(res_addr), 32'(e_addr));
      check("res_do", 32'(res_do), 32'(e_do));
      check("rvalid", 32'(rvalid), 32'(ev));
      if (ev != '0) check("rdata", 32'(rdata), 32'(ed));
      check("busy", 32'(busy), 32'(e_rd | e_wr | (ev != '0)));
      check("we_known", 32'($isunknown(we & req)), 32'd0);
      e_rd = 1'b0; e_wr = 1'b0;
      if (g >= 0) begin
         e_rd = !p_we[g]; e_wr = p_we[g]; e_addr = p_a[g]; e_do = p_d[g];
         if (p_we[g]) mdl_mem[p_a[g]] = p_d[g];
         else rq.push_back('{cyc + 2, g, mdl_mem[p_a[g]]});
`ifdef RES_ARB_LOCK_EN
         if (p_lk[g]) begin
            m_own_v = 1'b1; m_own = g;
         end else begin
            m_own_v = 1'b0; m_ptr = (g + 1) % N;
         end
`else
         m_ptr = (g + 1) % N;
`endif
      end
      cyc++;
      @(posedge clk);
      #1;
      if (g >= 0) p_v[g] = 1'b0;
      drive();
   endtask

   initial begin
      logic [7:0] v;
      n_err = 0; n_chk = 0; cyc = 0;
      for (int i = 0; i < 16384; i++) begin
         v = 8'($urandom);
         ram[i] = v; mdl_mem[i] = v;
      end
      ram[14'h0081] = 8'h05; mdl_mem[14'h0081] = 8'h05;
      for (int i = 0; i < N; i++) begin
         p_v[i] = 1'b0; p_we[i] = 1'b0; p_a[i] = '0; p_d[i] = '0; p_lk[i] = 1'b0;
      end
      model_reset();
      #1 reset = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 14'h0001, 8'h00, 1'b0);
      @(posedge clk); #2;
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_res_rd", 32'(res_rd), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rdata", 32'(rdata), 32'd0);
      model_reset();
      @(posedge clk); #3 reset = 1'b1;

      // read 0x0081 by requester 0
      set_req(0, 1'b0, 14'h0081, 8'h00, 1'b0);
      repeat (4) cycle();

      // all three requesters reading back to back
      for (int c = 0; c < 6; c++) begin
         for (int i = 0; i < N; i++)
            if (!p_v[i]) set_req(i, 1'b0, pick_addr(), 8'h00, 1'b0);
         cycle();
      end
      for (int i = 0; i < N; i++) p_v[i] = 1'b0;
      drive();
      repeat (4) cycle();

      // write then read of the top address
      set_req(1, 1'b1, 14'h3FFF, 8'h07, 1'b0);
      cycle();
      set_req(2, 1'b0, 14'h3FFF, 8'h00, 1'b0);
      repeat (4) cycle();

      // reset in the cycle after a read transfer
      set_req(0, 1'b0, 14'h0081, 8'h00, 1'b0);
      cycle();
      #2 reset = 1'b0;
      #1;
      check("rst_mid_res_rd", 32'(res_rd), 32'd0);
      check("rst_mid_addr", 32'(res_addr), 32'd0);
      model_reset();
      @(posedge clk); #1;
      check("rst_mid_rvalid", 32'(rvalid), 32'd0);
      @(posedge clk); #3 reset = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, 1'b0, pick_addr(), 8'h00, 1'b0);
      cycle();
      for (int i = 0; i < N; i++) p_v[i] = 1'b0;
      drive();

      // idle stretch: bus quiet, address holds, busy drains
      repeat (6) cycle();

`ifdef RES_ARB_LOCK_EN
      // requester 1 owns the arbiter for three transfers while requester 0 waits
      for (int k = 0; k < 4; k++) begin
         if (!p_v[1]) set_req(1, 1'b0, pick_addr(), 8'h00, (k < 3) ? 1'b1 : 1'b0);
         if (k > 0 && !p_v[0]) set_req(0, 1'b0, pick_addr(), 8'h00, 1'b0);
         cycle();
      end
      repeat (4) cycle();
`endif

      // randomized mixed traffic
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!p_v[i] && $urandom_range(0, 99) < 45) begin
`ifdef RES_ARB_LOCK_EN
               set_req(i, 1'($urandom_range(0, 1)), pick_addr(), 8'($urandom),
                       ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0);
`else
               set_req(i, 1'($urandom_range(0, 1)), pick_addr(), 8'($urandom), 1'b0);
`endif
            end
         end
         cycle();
      end
      for (int i = 0; i < N; i++) p_v[i] = 1'b0;
      drive();
      repeat (4) cycle();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
